// File: rtl/systolic_mac_array.sv
// systolic_mac_array: N x N output-stationary systolic array over four selectable semirings.
// Define SYSTOLIC_TROPICAL_EN to enable the max-plus datapath for mode 11 (otherwise mode 11 = modular).
`default_nettype none

module systolic_mac_array #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     mode,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_last,
  input  logic [N*W-1:0] in_a,
  input  logic [N*W-1:0] in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_row,
  output logic           busy
);

  localparam int CW = $clog2(2 * N);
  localparam int RW = $clog2(N);
  localparam logic [W-1:0] MAXV = '1;

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic          up_q, up_d;

  // ska/skb: per-row/column skew lines, entry at index i (or j), read at index 0
  logic [W-1:0] ska_q [N][N];
  logic [W-1:0] ska_d [N][N];
  logic [W-1:0] skb_q [N][N];
  logic [W-1:0] skb_d [N][N];
  logic [W-1:0] a_q   [N][N-1];
  logic [W-1:0] a_d   [N][N-1];
  logic [W-1:0] b_q   [N-1][N];
  logic [W-1:0] b_d   [N-1][N];
  logic [W-1:0] acc_q [N][N];
  logic [W-1:0] acc_d [N][N];
  logic [W-1:0] a_op  [N][N];
  logic [W-1:0] b_op  [N][N];

  logic          accept;
  logic          adv;
  logic          clear;
  logic [RW-1:0] row_idx;

  function automatic logic [W-1:0] mac_op(input logic [1:0] m, input logic [W-1:0] acc,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    logic [2*W:0]   sum;
    logic [W-1:0]   res;
`ifdef SYSTOLIC_TROPICAL_EN
    logic [W:0]     ts;
    logic [W-1:0]   tsat;
`endif
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    sum  = {{(W+1){1'b0}}, acc} + {1'b0, prod};
    case (m)
      2'b00: res = acc | (a & b);
      2'b10: res = (sum[2*W:W] != '0) ? MAXV : sum[W-1:0];
`ifdef SYSTOLIC_TROPICAL_EN
      2'b11: begin
        ts   = {1'b0, a} + {1'b0, b};
        tsat = ts[W] ? MAXV : ts[W-1:0];
        res  = (tsat > acc) ? tsat : acc;
      end
`endif
      default: res = sum[W-1:0];
    endcase
    return res;
  endfunction

  assign accept    = in_valid & in_ready;
  assign adv       = accept | (state_q == FLUSH);
  assign clear     = accept & (state_q == IDLE);
  assign in_ready  = up_q & ((state_q == IDLE) | (state_q == ACCUM));
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q != IDLE);
  assign row_idx   = cnt_q[RW-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    up_d    = 1'b1;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mode_d  = mode;
          cnt_d   = '0;
          state_d = in_last ? FLUSH : ACCUM;
        end
      end
      ACCUM: begin
        if (accept && in_last) begin
          cnt_d   = '0;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (cnt_q == CW'(2 * N - 2)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        if (out_ready) begin
          if (cnt_q == CW'(N - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
    endcase
  end

  // Bubbles (flush or idle) carry zeros, which are neutral for every semiring.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int d = 0; d < N; d++) begin
        ska_d[i][d] = ska_q[i][d];
        skb_d[i][d] = skb_q[i][d];
        if (adv) begin
          if (d == i) begin
            ska_d[i][d] = accept ? in_a[i*W +: W] : '0;
            skb_d[i][d] = accept ? in_b[i*W +: W] : '0;
          end else if (d < N - 1) begin
            ska_d[i][d] = ska_q[i][(d < N - 1) ? d + 1 : d];
            skb_d[i][d] = skb_q[i][(d < N - 1) ? d + 1 : d];
          end else begin
            ska_d[i][d] = '0;
            skb_d[i][d] = '0;
          end
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        a_op[i][j]  = (j == 0) ? ska_q[i][0] : a_q[i][(j > 0) ? j - 1 : 0];
        b_op[i][j]  = (i == 0) ? skb_q[j][0] : b_q[(i > 0) ? i - 1 : 0][j];
        acc_d[i][j] = clear ? '0 :
                      (adv ? mac_op(mode_q, acc_q[i][j], a_op[i][j], b_op[i][j]) : acc_q[i][j]);
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N - 1; j++) begin
        a_d[i][j] = adv ? a_op[i][j] : a_q[i][j];
        b_d[j][i] = adv ? b_op[j][i] : b_q[j][i];
      end
    end
  end

  always_comb begin
    out_row = '0;
    if (out_valid) begin
      for (int j = 0; j < N; j++) begin
        out_row[j*W +: W] = acc_q[row_idx][j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      up_q    <= 1'b0;
      ska_q   <= '{default: '0};
      skb_q   <= '{default: '0};
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      acc_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      up_q    <= up_d;
      ska_q   <= ska_d;
      skb_q   <= skb_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_systolic_mac_array.sv
// tb_systolic_mac_array: directed jobs with a row scoreboard built from a plain matrix model.
`default_nettype none

module tb_systolic_mac_array;
  localparam int N = 4;
  localparam int W = 4;
  localparam int MAXI = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     mode;
  logic           in_valid;
  logic           in_ready;
  logic           in_last;
  logic [N*W-1:0] in_a;
  logic [N*W-1:0] in_b;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out_row;
  logic           busy;

  systolic_mac_array #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;
  logic [N*W-1:0] exp_q[$];
  logic [N*W-1:0] ja[8];
  logic [N*W-1:0] jb[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  function automatic int op(input logic [1:0] m, input int acc, input int a, input int b);
    int s;
    case (m)
      2'b00: return acc | (a & b);
      2'b10: begin s = acc + a * b; return (s > MAXI) ? MAXI : s; end
`ifdef SYSTOLIC_TROPICAL_EN
      2'b11: begin s = a + b; if (s > MAXI) s = MAXI; return (acc > s) ? acc : s; end
`endif
      default: return (acc + a * b) % (1 << W);
    endcase
  endfunction

  task automatic model(input logic [1:0] m, input int nb);
    logic [N*W-1:0] row;
    int acc;
    for (int i = 0; i < N; i++) begin
      row = '0;
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int k = 0; k < nb; k++)
          acc = op(m, acc, int'(ja[k][i*W +: W]), int'(jb[k][j*W +: W]));
        row[j*W +: W] = acc[W-1:0];
      end
      exp_q.push_back(row);
    end
  endtask

  task automatic send_job(input logic [1:0] m, input int nb, input bit gaps, input bit push,
                          output int t_last);
    if (push) model(m, nb);
    t_last = cyc;
    for (int k = 0; k < nb; k++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      mode     = (k == 0) ? m : ~m;
      in_valid = 1'b1;
      in_a     = ja[k];
      in_b     = jb[k];
      in_last  = (k == nb - 1);
      for (int t = 0; t < 50 && !in_ready; t++) tick();
      t_last = cyc;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_a     = '0;
    in_b     = '0;
    check("ready_low_in_flush", {63'd0, in_ready}, 64'd0);
    check("busy_in_flush", {63'd0, busy}, 64'd1);
  endtask

  task automatic recv_job(input int stall, input int t_last);
    logic [N*W-1:0] held;
    logic [N*W-1:0] expv;
    out_ready = (stall == 0);
    for (int t = 0; t < 200 && !out_valid; t++) tick();
    check("out_valid_seen", {63'd0, out_valid}, 64'd1);
    check("latency", 64'(cyc - t_last), 64'(2 * N));
    for (int r = 0; r < N; r++) begin
      if (stall > 0) begin
        out_ready = 1'b0;
        held = out_row;
        repeat (stall) tick();
        check("row_stable_stall", {{(64-N*W){1'b0}}, out_row}, {{(64-N*W){1'b0}}, held});
        out_ready = 1'b1;
      end
      expv = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check($sformatf("row%0d", r), {{(64-N*W){1'b0}}, out_row}, {{(64-N*W){1'b0}}, expv});
      tick();
    end
    out_ready = 1'b0;
    check("idle_after_drain", {62'd0, out_valid, busy}, 64'd0);
  endtask

  task automatic load_fill(input int nb, input logic [W-1:0] av, input logic [W-1:0] bv);
    for (int k = 0; k < nb; k++) begin
      ja[k] = {N{av}};
      jb[k] = {N{bv}};
    end
  endtask

  initial begin
    int tl;
    rst_n = 1'b0; mode = '0; in_valid = 1'b0; in_last = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_row", {{(64-N*W){1'b0}}, out_row}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", {63'd0, in_ready}, 64'd0);
    tick();
    check("ready_after_edge", {63'd0, in_ready}, 64'd1);

    // Identity times identity, modular
    for (int k = 0; k < N; k++) begin
      ja[k] = '0; jb[k] = '0;
      ja[k][k*W +: W] = 1;
      jb[k][k*W +: W] = 1;
    end
    send_job(2'b01, N, 1'b0, 1'b1, tl);
    recv_job(0, tl);

    load_fill(N, 4'hF, 4'hF);
    send_job(2'b10, N, 1'b0, 1'b1, tl);
    recv_job(0, tl);
    send_job(2'b01, N, 1'b0, 1'b1, tl);
    recv_job(0, tl);

    ja[0] = 16'h000F; jb[0] = 16'h0101;
    send_job(2'b00, 1, 1'b0, 1'b1, tl);
    recv_job(0, tl);

    ja[0] = {N{4'd3}}; jb[0] = {N{4'd4}};
    ja[1] = {N{4'd9}}; jb[1] = {N{4'd9}};
    send_job(2'b11, 2, 1'b0, 1'b1, tl);
    recv_job(0, tl);

    // Random operands with input gaps and output back-pressure
    for (int k = 0; k < 5; k++) begin
      ja[k] = N*W'($urandom);
      jb[k] = N*W'($urandom);
    end
    send_job(2'b01, 5, 1'b1, 1'b1, tl);
    recv_job(5, tl);
    send_job(2'b10, 5, 1'b1, 1'b1, tl);
    recv_job(5, tl);
    send_job(2'b00, 5, 1'b0, 1'b1, tl);
    recv_job(0, tl);

    // Abandon a job in FLUSH, then run a fresh one
    load_fill(N, 4'h7, 4'h5);
    send_job(2'b01, N, 1'b0, 1'b0, tl);
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_outs", {{(63-N*W){1'b0}}, out_valid, out_row}, 64'd0);
    check("midrst_ready", {63'd0, in_ready}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    load_fill(2, 4'h2, 4'h3);
    send_job(2'b01, 2, 1'b0, 1'b1, tl);
    recv_job(0, tl);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
